// File: rtl/step_clock_gen_pkg.sv
// Shared types and constants for the single-step / free-run CPU clock-enable generator.
package step_clk_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } step_state_t;

  localparam int DEB_TICKS_DEF = 4;
  localparam int DEB_CNT_W     = 4;

endpackage

// File: rtl/step_clock_gen_if.sv
// Slow-clock, button and mode inputs plus the CPU clock-enable outputs of step_clock_gen.
interface step_clock_gen_if #(parameter int CNT_W = 8);
  logic             tick;
  logic             key_n;
  logic             run_mode;
  logic             cpu_en;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;

  modport master (output tick, key_n, run_mode, input cpu_en, step_cnt, busy);
  modport slave  (input tick, key_n, run_mode, output cpu_en, step_cnt, busy);
endinterface

// File: rtl/step_clock_gen_sync_rise.sv
// Two-flop synchronizer with a registered rising-edge strobe.
module sync_rise (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic       meta, sync, prev, armed;
  logic [1:0] vld;

  // armed only sets once a genuinely synchronized low is seen, so a level
  // already high when reset releases never looks like an edge
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      vld   <= 2'b00;
      rise  <= 1'b0;
    end else begin
      meta  <= d;
      sync  <= meta;
      prev  <= sync;
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~sync);
      rise  <= sync & ~prev & armed;
    end
  end
endmodule

// File: rtl/step_clock_gen.sv
// CPU clock-enable generator: one pulse per slow tick in free-run, one per debounced key press in step mode.
module step_clock_gen
  import step_clk_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int CNT_W     = 8
) (
  input logic              clk_in,
  input logic              rst,
  step_clock_gen_if.slave  bus
);
  // state        | meaning
  // IDLE         | key released and stable, waiting for a low sample
  // PRESS_WAIT   | key low, counting consecutive low tick samples
  // HELD         | press accepted (pulse issued), waiting for a high sample
  // RELEASE_WAIT | key high, counting consecutive high tick samples

  localparam logic [DEB_CNT_W-1:0] DEB_TC = DEB_CNT_W'(DEB_TICKS);

  logic                 tick_rise;
  logic                 key_m, key_s, run_m, run_s, run_prev, mode_chg;
  logic                 fire, cpu_en_q;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]     step_cnt_q;
  step_state_t          state_q, state_d;

  sync_rise u_tick_sync (.clk_in(clk_in), .rst(rst), .d(bus.tick), .rise(tick_rise));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      key_m    <= 1'b0;
      key_s    <= 1'b0;
      run_m    <= 1'b0;
      run_s    <= 1'b0;
      run_prev <= 1'b0;
    end else begin
      key_m    <= bus.key_n;
      key_s    <= key_m;
      run_m    <= bus.run_mode;
      run_s    <= run_m;
      run_prev <= run_s;
    end
  end

  assign mode_chg = run_s ^ run_prev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (mode_chg || run_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (tick_rise) begin
      case (state_q)
        IDLE: if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = DEB_CNT_W'(1);
        end
        PRESS_WAIT: if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q + 1'b1 == DEB_TC) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        HELD: if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = DEB_CNT_W'(1);
        end
        RELEASE_WAIT: if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q + 1'b1 == DEB_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_en_q   <= (run_s & tick_rise & ~mode_chg) | fire;
      step_cnt_q <= step_cnt_q + CNT_W'(cpu_en_q);
    end
  end

  assign bus.cpu_en   = cpu_en_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/step_clock_gen.md
STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 Parameter DEB_TICKS, default 4, meaning consecutive stable tick samples needed to accept a key level change (range 2..15).
REQ-002 Parameter CNT_W, default 8, meaning width of step_cnt.
REQ-003 clk_in  input  1  system clock; all state in this block is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  divided slow clock from the upstream frequency divider, treated as an asynchronous level.
REQ-006 key_n  input  1  raw single-step push button, active-low, bouncing.
REQ-007 run_mode  input  1  switch: 1 = free-run, 0 = single-step.
REQ-008 cpu_en  output  1  one-clk_in-cycle clock-enable pulse to the CPU core.
REQ-009 step_cnt  output  CNT_W  count of cpu_en pulses issued since reset.
REQ-010 busy  output  1  high while the debounce FSM is in any state other than IDLE.

Function
REQ-011 tick, key_n and run_mode shall each pass through a 2-flop synchronizer before use.
REQ-012 tick_rise shall be a one-cycle strobe, asserted when synchronized tick is 1 and its previous registered value is 0.
REQ-013 Run mode: cpu_en shall pulse once per tick_rise, registered, i.e. asserted exactly 4 clk_in rising edges after tick goes high at the pin.
REQ-014 Step mode: the FSM shall have states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE -> PRESS_WAIT when synchronized key_n is 0 on a tick_rise; the stable counter is loaded with 1.
REQ-016 PRESS_WAIT: on each tick_rise with key_n 0, increment the counter; on reaching DEB_TICKS go to HELD and assert cpu_en for exactly one clk_in cycle; on a tick_rise with key_n 1, return to IDLE with the counter cleared.
REQ-017 HELD -> RELEASE_WAIT on a tick_rise with key_n 1 (counter loaded with 1); holding the key shall never produce a second pulse.
REQ-018 RELEASE_WAIT: on each tick_rise with key_n 1, increment; on reaching DEB_TICKS go to IDLE; on a tick_rise with key_n 0, return to HELD.
REQ-019 The FSM shall sample key_n only on tick_rise; no state change between tick_rise strobes.
REQ-020 Mode change: whenever synchronized run_mode differs from its previous registered value, the FSM shall go to IDLE with the counter cleared; no cpu_en shall be issued in that cycle.
REQ-021 In run mode the FSM shall be held in IDLE, so busy = 0.
REQ-022 step_cnt shall increment by 1 in the cycle after each cpu_en pulse and wrap from 2^CNT_W-1 to 0.
REQ-023 cpu_en shall never be high in two consecutive clk_in cycles.

Reset
REQ-024 While rst = 0: cpu_en = 0, step_cnt = 0, busy = 0, FSM = IDLE, debounce counter = 0, and all synchronizer and edge flops = 0.
REQ-025 Reset asserted mid-debounce or mid-pulse shall abort immediately and must not produce a cpu_en after release.
REQ-026 After rst rises, a tick already high shall not produce a tick_rise until tick has been seen low.

Structure
REQ-027 A shared package step_clk_pkg shall hold the FSM state enumeration (2-bit encoding) and the DEB_TICKS default constant.
REQ-028 One sub-module, sync_rise (2-flop synchronizer plus rising-edge strobe, with the same rst/clk_in), shall be instantiated for tick; key_n and run_mode shall use its synchronizer output only.

Verification
REQ-029 Run mode, tick toggled every 11 clk_in cycles for 10 periods -> exactly 10 cpu_en pulses, each 4 cycles after the tick rise, and step_cnt = 10.
REQ-030 Step mode, key_n bouncing 0/1/0 across 3 ticks, then held 0 for 4 ticks, then held 0 for 20 more -> exactly 1 cpu_en and step_cnt = 1.
REQ-031 Step mode, release with bounce (1 for 2 ticks, 0 for 1, then 1 for 4) followed by a clean press -> FSM returns HELD then IDLE and exactly 1 more cpu_en (total 2).
REQ-032 Key held 0 and run_mode switched 0->1 while in PRESS_WAIT with counter = 3 -> no step pulse; busy = 0 within 3 cycles; run pulses then follow ticks.
REQ-033 Preload step_cnt to 255 via 255 run-mode pulses, then issue 1 more -> step_cnt = 0.
REQ-034 rst pulsed low during PRESS_WAIT -> all outputs 0, and no cpu_en until a fresh DEB_TICKS-stable press.
